// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] sel_t;
    typedef logic [3:0] req_t;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic req_t sel_onehot(input sel_t s);
        return req_t'(1) << s;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first set request at or after start, wrapping.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         start,
    output logic               found,
    output logic [1:0]         idx
);

    sel_t              cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // hit[gi] means the requester gi steps after start is asking
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_order
        assign cand[gi] = start + sel_t'(gi);
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        found = |req;
        idx   = start;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) idx = cand[i];
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, registered outputs.
// Optional forced rotation after MAX_HOLD cycles when MUX4_ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
)
(
    input  logic               clk,
    input  logic               n_reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         sel,
    output logic               busy
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    arb_state_t state_reg;
    sel_t       last_reg;
    sel_t       sel_reg;
    req_t       gnt_reg;
    logic       busy_reg;

    logic pick_found;
    sel_t pick_idx;
    logic timeout;
    logic rearb;
    logic new_grant;

    // Search always starts just past the most recent grant; in GRANT last == sel
    rr_pick4 u_pick (
        .req   (req),
        .start (last_reg + 2'd1),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_reg;

    assign timeout = (state_reg == GRANT) && (hold_cnt_reg == HOLD_LAST) &&
                     ((req & ~sel_onehot(sel_reg)) != '0);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hold_cnt_reg <= '0;
        end else if (new_grant) begin
            hold_cnt_reg <= '0;
        end else if (state_reg == GRANT && hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Re-arbitrate when idle, when the holder drops, or on forced rotation
    assign rearb     = (state_reg == IDLE) || !req[sel_reg] || timeout;
    assign new_grant = rearb && pick_found;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= IDLE;
            last_reg  <= 2'd3;
            sel_reg   <= 2'd0;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else if (new_grant) begin
            state_reg <= GRANT;
            last_reg  <= pick_idx;
            sel_reg   <= pick_idx;
            gnt_reg   <= sel_onehot(pick_idx);
            busy_reg  <= 1'b1;
        end else if (rearb) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end
    end

    assign gnt  = gnt_reg;
    assign sel  = sel_reg;
    assign busy = busy_reg;

endmodule
